// File: rtl/errmon_pkg.sv
// Shared definitions for the CPU error monitor: error bit indices, fatal mask, FSM states.
package errmon_pkg;

  localparam int ERR_ZERO = 0;
  localparam int ERR_NUM  = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_MIS  = 3;

  localparam logic [3:0] FATAL_MASK = 4'b1100;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  function automatic logic is_fatal(input logic [3:0] code);
    return |(code & FATAL_MASK);
  endfunction

endpackage

// File: rtl/errmon_fifo.sv
// First-word-fall-through FIFO with registered pointers, occupancy count and sticky drop flag.
module errmon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q;

  logic valid, full, pop, wr_en, drop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = valid & ready_i;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign wr_en = push_i & (~full | pop);
  assign drop  = push_i & full & ~pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the zeroed count hides stale entries and data_o is gated by valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = valid;
  assign data_o  = valid ? mem_q[rd_ptr_q] : '0;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/cpu_error_monitor.sv
// Sticky error flags, saturating cycle counter and registered halt for the single-cycle CPU.
// Optional time-stamped error log FIFO enabled by defining ERRMON_LOG_EN.
module cpu_error_monitor
  import errmon_pkg::*;
#(
  parameter int CYC_W     = 32,
  parameter int LOG_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              err_zero_i,
  input  logic              err_num_i,
  input  logic              addr_ovf_i,
  input  logic              misalign_i,
  input  logic [31:0]       pc_i,
  output logic              halt_o,
  output logic [31:0]       halt_pc_o,
  output logic [3:0]        err_flags_o,
  output logic [CYC_W-1:0]  cycle_cnt_o,
  output logic              log_valid_o,
  input  logic              log_ready_i,
  output logic [CYC_W+35:0] log_data_o,
  output logic              log_ovf_o
);

  logic [3:0]       code;
  state_e           state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [3:0]       flags_q, flags_d;
  logic [31:0]      halt_pc_q, halt_pc_d;
  logic             push;

  assign code[ERR_ZERO] = err_zero_i;
  assign code[ERR_NUM]  = err_num_i;
  assign code[ERR_ADDR] = addr_ovf_i;
  assign code[ERR_MIS]  = misalign_i;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flags_d   = flags_q;
    halt_pc_d = halt_pc_q;
    push      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CYC_W'(1);
        flags_d = flags_q | code;
        push    = |code;
        if (is_fatal(code)) begin
          state_d   = ST_HALT;
          halt_pc_d = pc_i;
        end
      end
      default: ;  // HALT is terminal until reset; everything stays frozen
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      flags_q   <= '0;
      halt_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      halt_pc_q <= halt_pc_d;
    end
  end

  assign halt_o      = (state_q == ST_HALT);
  assign halt_pc_o   = halt_pc_q;
  assign err_flags_o = flags_q;
  assign cycle_cnt_o = cnt_q;

`ifdef ERRMON_LOG_EN
  // Timestamp is the pre-increment count, so the first cycle after reset logs 0.
  errmon_fifo #(
    .WIDTH (CYC_W + 36),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  ({cnt_q, pc_i, code}),
    .ready_i (log_ready_i),
    .valid_o (log_valid_o),
    .data_o  (log_data_o),
    .ovf_o   (log_ovf_o)
  );
`else
  logic [1:0]                   unused_log;
  logic [$clog2(LOG_DEPTH)-1:0] unused_depth;

  assign unused_log   = {log_ready_i, push};
  assign unused_depth = '0;
  assign log_valid_o  = 1'b0;
  assign log_data_o   = '0;
  assign log_ovf_o    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_error_monitor.sv
// Scoreboard bench for cpu_error_monitor: a 32-bit-counter instance plus a CYC_W=4 instance.
module tb_cpu_error_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        ez, en, ao, mi;
  logic [31:0] pc;
  logic        ready;

  logic        halt, halt_s;
  logic [31:0] hpc, hpc_s;
  logic [3:0]  flags, flags_s;
  logic [31:0] cnt;
  logic [3:0]  cnt_s;
  logic        lvalid, lvalid_s;
  logic [67:0] ldata;
  logic [39:0] ldata_s;
  logic        lovf, lovf_s;

  cpu_error_monitor #(.CYC_W(32), .LOG_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .err_zero_i(ez), .err_num_i(en), .addr_ovf_i(ao),
    .misalign_i(mi), .pc_i(pc), .halt_o(halt), .halt_pc_o(hpc), .err_flags_o(flags),
    .cycle_cnt_o(cnt), .log_valid_o(lvalid), .log_ready_i(ready), .log_data_o(ldata),
    .log_ovf_o(lovf)
  );

  cpu_error_monitor #(.CYC_W(4), .LOG_DEPTH(8)) dut_s (
    .clk_i(clk), .rst_i(rst), .err_zero_i(ez), .err_num_i(en), .addr_ovf_i(ao),
    .misalign_i(mi), .pc_i(pc), .halt_o(halt_s), .halt_pc_o(hpc_s), .err_flags_o(flags_s),
    .cycle_cnt_o(cnt_s), .log_valid_o(lvalid_s), .log_ready_i(ready), .log_data_o(ldata_s),
    .log_ovf_o(lovf_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        halt;
    logic [31:0] hpc;
    logic [3:0]  flags;
    logic [31:0] cnt;
    logic [3:0]  cnt_s;
    logic        ovf;
    logic        valid;
  } exp_t;

  exp_t        exp_q[$];
  logic [67:0] log_q[$];

  logic        m_halt;
  logic [31:0] m_hpc;
  logic [3:0]  m_flags;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt_s;
  logic        m_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_halt = 1'b0; m_hpc = '0; m_flags = '0; m_cnt = '0; m_cnt_s = '0; m_ovf = 1'b0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic set_in(input logic z, input logic n, input logic a, input logic m);
    ez = z; en = n; ao = a; mi = m;
    pc = m_cnt << 2;
  endtask

  // One clock: predict, push expectation, clock, pop and compare.
  task automatic step();
    logic [3:0] code;
    exp_t       e;
    code = {mi, ao, en, ez};
`ifdef ERRMON_LOG_EN
    check("log_valid_pre", lvalid, log_q.size() != 0);
    if (ready && log_q.size() != 0) begin
      check("log_data", ldata, log_q[0]);
      void'(log_q.pop_front());
    end
    if (!m_halt && code != 4'b0000) begin
      if (log_q.size() < 8) log_q.push_back({m_cnt, pc, code});
      else m_ovf = 1'b1;
    end
`endif
    if (!m_halt) begin
      m_flags = m_flags | code;
      m_cnt   = m_cnt + 1;
      if (m_cnt_s != 4'hF) m_cnt_s = m_cnt_s + 4'd1;
      if (ao || mi) begin
        m_halt = 1'b1;
        m_hpc  = pc;
      end
    end
    exp_q.push_back('{m_halt, m_hpc, m_flags, m_cnt, m_cnt_s, m_ovf, log_q.size() != 0});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("halt", halt, e.halt);
    check("halt_pc", hpc, e.hpc);
    check("flags", flags, e.flags);
    check("cycle_cnt", cnt, e.cnt);
    check("cycle_cnt_w4", cnt_s, e.cnt_s);
    check("halt_w4", halt_s, e.halt);
    check("log_ovf", lovf, e.ovf);
    check("log_valid", lvalid, e.valid);
    check("log_valid_w4", lvalid_s, e.valid);
`ifndef ERRMON_LOG_EN
    check("log_data_off", ldata, '0);
`endif
  endtask

  // Assert reset at a non-edge time and verify every output clears immediately.
  task automatic do_reset(input int offset);
    #(offset);
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_halt", halt, 1'b0);
    check("rst_halt_pc", hpc, '0);
    check("rst_flags", flags, '0);
    check("rst_cnt", cnt, '0);
    check("rst_cnt_w4", cnt_s, '0);
    check("rst_log_valid", lvalid, 1'b0);
    check("rst_log_data", ldata, '0);
    check("rst_log_ovf", lovf, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0;
    ez = 0; en = 0; ao = 0; mi = 0; pc = '0;
    model_clear();
    #12;

    // Idle run
    do_reset(0);
    repeat (10) begin set_in(0, 0, 0, 0); step(); end
    check("t1_cnt10", cnt, 32'd10);

    // Non-fatal errors, then drain
    do_reset(0);
    for (int c = 0; c < 8; c++) begin
      set_in(c == 3, c == 5, 0, 0);
      step();
    end
    check("t2_flags", flags, 4'b0011);
    check("t2_halt", halt, 1'b0);
    ready = 1'b1;
    repeat (4) begin set_in(0, 0, 0, 0); step(); end
    ready = 1'b0;

    // Fatal double error at cycle 7, later errors ignored
    do_reset(0);
    for (int c = 0; c < 8; c++) begin
      set_in(0, 0, c == 7, c == 7);
      step();
    end
    check("t3_halt_pc", hpc, 32'h1C);
    repeat (5) begin set_in(1, 1, 1, 1); step(); end
    check("t3_flags", flags, 4'b1100);
    check("t3_cnt_hold", cnt, 32'd8);
    ready = 1'b1;
    repeat (2) begin set_in(0, 0, 0, 0); step(); end
    ready = 1'b0;

    // Overflow the log, then full+push+pop on one edge
    do_reset(0);
    for (int c = 0; c < 9; c++) begin
      set_in(c % 2 == 0, c % 2 == 1, 0, 0);
      step();
    end
`ifdef ERRMON_LOG_EN
    check("t4_ovf", lovf, 1'b1);
`endif
    ready = 1'b1;
    set_in(1, 0, 0, 0);
    step();
    repeat (3) begin set_in(0, 0, 0, 0); step(); end

    // Reset mid-drain at a non-edge time
    do_reset(3);
    repeat (2) begin set_in(0, 0, 0, 0); step(); end
    ready = 1'b0;

    // Counter saturation on the 4-bit instance
    do_reset(0);
    repeat (20) begin set_in(0, 0, 0, 0); step(); end
    check("t6_sat_w4", cnt_s, 4'd15);
    check("t6_cnt20", cnt, 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
